// File: rtl/io_port_ctrl.sv
// ---------------------------------------------------------------------------
// io_port_ctrl
//
// Bridges the CPU's IN/OUT instructions (MEMWB stage) to external peripheral
// ports.
//   * Write path: OUT instructions are posted into a small FIFO. The FIFO
//     head is presented to the peripheral through a valid/ready handshake.
//   * Read path: an IN instruction runs a req/ack handshake with the
//     peripheral. Before it starts, all earlier posted writes must drain. If
//     the peripheral never answers, a timeout ends the read.
//
// Ports
//   clk, reset          : clock and asynchronous active-low reset
//   IO_port_ID          : port address from EX/MEMWB
//   IO_write_data       : OUT data
//   IO_write_strobe     : OUT request
//   IO_read_strobe      : IN request
//   IO_read_data        : registered IN result
//   io_stall            : pipeline hold request
//   out_port_id/out_data: FIFO head toward the peripheral
//   out_valid/out_ready : write-path handshake
//   in_port_id          : read address latched when the request starts
//   in_req/in_ack       : read-path handshake
//   in_data             : peripheral read data, sampled while in_ack is high
//   fifo_count          : occupied FIFO entries
//   rd_timeout_err      : sticky flag, set when a read times out
//   rd_state            : current read-FSM state (debug visibility)
//
// Handshake semantics
//   Write path (valid/ready): a beat transfers on every rising edge where
//   out_valid and out_ready are both high. out_valid never depends on
//   out_ready. out_port_id/out_data stay stable while out_valid is high and
//   no transfer has occurred.
//   Read path (req/ack): in_req is high for every cycle of the REQ state.
//   The first cycle with in_ack high completes the read. in_req drops on
//   the following cycle. in_ack outside REQ has no effect.
// ---------------------------------------------------------------------------
module io_port_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_TIMEOUT = 255,
    localparam int unsigned AW = $clog2(FIFO_DEPTH),
    localparam int unsigned CW = AW + 1,
    localparam int unsigned TW = $clog2(RD_TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    IO_port_ID,
    input  logic [7:0]    IO_write_data,
    input  logic          IO_write_strobe,
    input  logic          IO_read_strobe,
    output logic [7:0]    IO_read_data,
    output logic          io_stall,
    output logic [7:0]    out_port_id,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    in_port_id,
    output logic          in_req,
    input  logic          in_ack,
    input  logic [7:0]    in_data,
    output logic [CW-1:0] fifo_count,
    output logic          rd_timeout_err,
    output logic [1:0]    rd_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_WR = 2'd1,
        ST_REQ     = 2'd2,
        ST_DONE    = 2'd3
    } rd_state_e;

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [15:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_full;
    logic          push;
    logic          pop;

    always_comb begin
        fifo_full = (count_q == CW'(FIFO_DEPTH));
        out_valid = (count_q != '0);
        pop       = out_valid & out_ready;
        // When the FIFO is full, a same-cycle pop frees the head slot.
        // wr_ptr equals rd_ptr in that case, so the new entry lands in the
        // slot being freed.
        push      = IO_write_strobe & (~fifo_full | pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {IO_port_ID, IO_write_data};
        end

        // The pointers are power-of-two wide, so they wrap naturally.
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // The head entry is read straight from storage, adding no latency.
    assign {out_port_id, out_data} = mem_q[rd_ptr_q];
    assign fifo_count              = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: state register
    // ------------------------------------------------------------------
    rd_state_e state_q, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: next state
    // ------------------------------------------------------------------
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;

    // The request lasts at most RD_TIMEOUT cycles. The counter holds the
    // number of REQ cycles already spent.
    assign tmo_hit = (tmo_q == TW'(RD_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                // A write takes priority. A read arriving with a write
                // waits in IDLE.
                if (IO_read_strobe && !IO_write_strobe) begin
                    state_d = (count_q == '0) ? ST_REQ : ST_WAIT_WR;
                end
            end
            ST_WAIT_WR: begin
                if (count_q == '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (in_ack || tmo_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read FSM: outputs
    // ------------------------------------------------------------------
    logic rd_stall;

    always_comb begin
        in_req   = (state_q == ST_REQ);
        rd_stall = IO_read_strobe & (state_q != ST_DONE);
        // Gate the stall with reset so that it reads 0 while reset is held,
        // regardless of the strobes.
        io_stall = reset & ((IO_write_strobe & ~push) | rd_stall);
        rd_state = state_q;
    end

    // ------------------------------------------------------------------
    // Read datapath
    // ------------------------------------------------------------------
    logic [7:0] rd_data_q, rd_data_d;
    logic [7:0] in_port_id_q, in_port_id_d;
    logic       err_q, err_d;
    logic       enter_req;

    always_comb begin
        enter_req    = (state_q != ST_REQ) && (state_d == ST_REQ);
        in_port_id_d = enter_req ? IO_port_ID : in_port_id_q;

        tmo_d = tmo_q;
        if (enter_req) begin
            tmo_d = '0;
        end else if (state_q == ST_REQ) begin
            tmo_d = tmo_q + TW'(1);
        end

        rd_data_d = rd_data_q;
        err_d     = err_q;
        if (state_q == ST_REQ) begin
            if (in_ack) begin
                rd_data_d = in_data;
            end else if (tmo_hit) begin
                rd_data_d = 8'hFF;
                err_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q        <= '0;
            rd_data_q    <= 8'h00;
            in_port_id_q <= 8'h00;
            err_q        <= 1'b0;
        end else begin
            tmo_q        <= tmo_d;
            rd_data_q    <= rd_data_d;
            in_port_id_q <= in_port_id_d;
            err_q        <= err_d;
        end
    end

    assign IO_read_data   = rd_data_q;
    assign in_port_id     = in_port_id_q;
    assign rd_timeout_err = err_q;

endmodule
